// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM state type and CON encodings for the serial add/sub sequencer
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic CON_ADD = 1'b1;
  localparam logic CON_SUB = 1'b0;
endpackage

// File: rtl/serial_addsub_seq_slice.sv
// addsub2_slice: combinational 2-bit add/sub slice with majority carries
//  A0,A1,B0,B1 operand bits; BCI carry/borrow-in; CON 1=add 0=sub
//  S0,S1 sum bits; BCO carry-out; CI1 carry into bit 1 (used for overflow)
module addsub2_slice
  import serial_addsub_pkg::*;
(
  input  logic A0,
  input  logic A1,
  input  logic B0,
  input  logic B1,
  input  logic BCI,
  input  logic CON,
  output logic S0,
  output logic S1,
  output logic BCO,
  output logic CI1
);
  logic bp0, bp1;
  always_comb begin
    bp0 = (CON == CON_ADD) ? B0 : ~B0;
    bp1 = (CON == CON_ADD) ? B1 : ~B1;
    S0  = A0 ^ bp0 ^ BCI;
    CI1 = (A0 & bp0) | (A0 & BCI) | (bp0 & BCI);
    S1  = A1 ^ bp1 ^ CI1;
    BCO = (A1 & bp1) | (A1 & CI1) | (bp1 & CI1);
  end
endmodule

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: WIDTH-bit add/sub computed 2 bits per cycle with a START/BUSY/DONE handshake
//  CK clock; RN async active-low reset; START/CON/A/B request and operands (captured on accept)
//  BUSY high in RUN/FIN; DONE one-cycle pulse; S result; BCO carry-out / no-borrow
//  OVF signed overflow, present only when SERIAL_ADDSUB_OVF_EN is defined
module serial_addsub_seq
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic             CON,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             BCO
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             OVF
`endif
);
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
    $error("serial_addsub_seq: WIDTH must be even and >= 2");
  end
  state_t state, nxt;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] a_q, b_q;
  logic con_q, carry;
  logic s0, s1, bco, ci1;
  logic [1:0] a_k, b_k;
  // {count,0} is the LSB index of the current bit pair
  assign a_k = a_q[{count, 1'b0} +: 2];
  assign b_k = b_q[{count, 1'b0} +: 2];
  addsub2_slice u_slice (
    .A0(a_k[0]), .A1(a_k[1]), .B0(b_k[0]), .B1(b_k[1]),
    .BCI(carry), .CON(con_q),
    .S0(s0), .S1(s1), .BCO(bco), .CI1(ci1)
  );
  always_ff @(posedge CK or negedge RN)
    if (!RN) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt  = state == IDLE ? (START ? RUN : IDLE) :
           state == RUN  ? (count == LAST ? FIN : RUN) : IDLE;
    BUSY = state != IDLE;
    DONE = state == FIN;
  end
  always_ff @(posedge CK or negedge RN)
    if (!RN) begin
      a_q   <= '0;
      b_q   <= '0;
      con_q <= 1'b0;
      carry <= 1'b0;
      count <= '0;
      S     <= '0;
      BCO   <= 1'b0;
    end else if (state == IDLE && START) begin
      a_q   <= A;
      b_q   <= B;
      con_q <= CON;
      // subtract seeds carry-in 1 to complete the two's-complement of B
      carry <= ~CON;
      count <= '0;
      S     <= '0;
    end else if (state == RUN) begin
      S[{count, 1'b0} +: 2] <= {s1, s0};
      carry <= bco;
      if (count != LAST) count <= count + 1'b1;
      else BCO <= bco;
    end
`ifdef SERIAL_ADDSUB_OVF_EN
  always_ff @(posedge CK or negedge RN)
    if (!RN) OVF <= 1'b0;
    else if (state == RUN && count == LAST) OVF <= ci1 ^ bco;
`endif
endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb_serial_addsub_seq: directed self-checking bench for serial_addsub_seq (WIDTH=16 and WIDTH=2)
module tb_serial_addsub_seq;
  logic CK = 1'b0, RN = 1'b0, START = 1'b0, CON = 1'b0;
  logic [15:0] A = '0, B = '0, S;
  logic BUSY, DONE, BCO;
  logic start2 = 1'b0, con2 = 1'b0, busy2, done2, bco2;
  logic [1:0] a2 = '0, b2 = '0, s2;
  int errors = 0, checks = 0;
  int done_cyc, done_cnt, busy_cnt;
  logic [15:0] s_at;
  logic bco_at, ovf_at;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic OVF, ovf2;
`endif
  always #5 CK = ~CK;
  serial_addsub_seq #(.WIDTH(16)) dut (
    .CK(CK), .RN(RN), .START(START), .CON(CON), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .S(S), .BCO(BCO)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .OVF(OVF)
`endif
  );
  serial_addsub_seq #(.WIDTH(2)) dut2 (
    .CK(CK), .RN(RN), .START(start2), .CON(con2), .A(a2), .B(b2),
    .BUSY(busy2), .DONE(done2), .S(s2), .BCO(bco2)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .OVF(ovf2)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic con, input logic [15:0] a, input logic [15:0] b, input bit inj);
    @(negedge CK);
    CON = con; A = a; B = b; START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        s_at = S; bco_at = BCO;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_at = OVF;
`endif
      end
      if (inj && (c == 3 || c == 9)) begin
        START = 1'b1; A = 16'hAAAA; B = 16'h5555; CON = ~con;
      end else START = 1'b0;
      @(posedge CK); #1;
    end
    START = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_s", S, 0);
    check("rst_bco", BCO, 0);
    @(negedge CK); RN = 1'b1;
    run_op(1'b1, 16'h1234, 16'h4321, 0);
    check("add1_s", s_at, 16'h5555);
    check("add1_bco", bco_at, 0);
    check("add1_done_cyc", done_cyc, 9);
    check("add1_busy_cnt", busy_cnt, 9);
    check("add1_done_cnt", done_cnt, 1);
    check("add1_s_held", S, 16'h5555);
    run_op(1'b1, 16'hFFFF, 16'h0001, 0);
    check("addwrap_s", s_at, 16'h0000);
    check("addwrap_bco", bco_at, 1);
    run_op(1'b0, 16'h0005, 16'h0003, 0);
    check("sub_pos_s", s_at, 16'h0002);
    check("sub_pos_bco", bco_at, 1);
    run_op(1'b0, 16'h0003, 16'h0005, 0);
    check("sub_neg_s", s_at, 16'hFFFE);
    check("sub_neg_bco", bco_at, 0);
    run_op(1'b1, 16'h7FFF, 16'h0001, 0);
    check("addovf_s", s_at, 16'h8000);
    check("addovf_bco", bco_at, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("addovf_ovf", ovf_at, 1);
`endif
    run_op(1'b0, 16'h8000, 16'h0001, 0);
    check("subovf_s", s_at, 16'h7FFF);
    check("subovf_bco", bco_at, 1);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("subovf_ovf", ovf_at, 1);
`endif
    run_op(1'b1, 16'h1234, 16'h4321, 1);
    check("ign_s", s_at, 16'h5555);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_busy_cnt", busy_cnt, 9);
    @(negedge CK);
    CON = 1'b0; A = 16'h0003; B = 16'h0005; START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    repeat (3) @(posedge CK);
    #2 RN = 1'b0;
    #1;
    check("arst_busy", BUSY, 0);
    check("arst_done", DONE, 0);
    check("arst_s", S, 0);
    check("arst_bco", BCO, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("arst_ovf", OVF, 0);
`endif
    done_cnt = 0;
    repeat (12) begin
      @(posedge CK); #1;
      if (DONE || BUSY) done_cnt++;
    end
    check("arst_quiet", done_cnt, 0);
    @(negedge CK); RN = 1'b1;
    run_op(1'b1, 16'h0001, 16'h0001, 0);
    check("post_rst_s", s_at, 16'h0002);
    check("post_rst_bco", bco_at, 0);
    check("post_rst_done_cyc", done_cyc, 9);
    @(negedge CK);
    con2 = 1'b1; a2 = 2'b11; b2 = 2'b01; start2 = 1'b1;
    @(posedge CK); #1;
    start2 = 1'b0;
    done_cyc = 0; done_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (done2) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        s_at = {14'd0, s2}; bco_at = bco2;
      end
      @(posedge CK); #1;
    end
    check("w2_s", s_at, 16'h0000);
    check("w2_bco", bco_at, 1);
    check("w2_done_cyc", done_cyc, 2);
    check("w2_done_cnt", done_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
